// File: rtl/move_sequencer.sv
// move_sequencer
// Game-flow controller for an 8x8 Connect-Four board store. Accepts column
// moves, issues the drop write, then walks the cells around the dropped piece
// one read per cycle to detect WIN_LEN-in-a-row. Tracks turn, win and draw.
// The board read port is lent to the display scanner whenever no move is in
// flight (IDLE without a pending move, and OVER).
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   move_valid/move_col      move request and requested column
//   move_ready               high in IDLE; a move is taken when valid&ready
//   move_reject              one-cycle pulse after a move into a full column
//   board_enable/row/col     board store access
//   board_data_in/write      piece code and write strobe (DROP only)
//   board_drop_allowed       store: addressed column not full
//   board_row_to_drop        store: landing row of addressed column
//   board_data_out           store: combinational read data
//   disp_row/disp_col        display read address
//   disp_data/disp_grant     display read data, valid while granted
//   current_player           2'b01 player 1, 2'b10 player 2
//   winner/game_over/draw    game result, sticky until rst
module move_sequencer #(
    parameter int INIT_CYCLES = 66,
    parameter int WIN_LEN     = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       move_valid,
    input  logic [2:0] move_col,
    output logic       move_ready,
    output logic       move_reject,
    output logic       board_enable,
    output logic [2:0] board_row,
    output logic [2:0] board_col,
    output logic [1:0] board_data_in,
    output logic       board_write,
    input  logic       board_drop_allowed,
    input  logic [3:0] board_row_to_drop,
    input  logic [1:0] board_data_out,
    input  logic [2:0] disp_row,
    input  logic [2:0] disp_col,
    output logic [1:0] disp_data,
    output logic       disp_grant,
    output logic [1:0] current_player,
    output logic [1:0] winner,
    output logic       game_over,
    output logic       draw
);

    localparam int INIT_W = $clog2(INIT_CYCLES + 1);
    localparam int K_W    = $clog2(WIN_LEN);
    localparam int CNT_W  = $clog2(2 * WIN_LEN);

    typedef enum logic [2:0] {INIT, IDLE, DROP, SCAN, OVER} state_t;

    // Direction order; each even/odd pair forms one axis.
    localparam logic signed [4:0] DROW [8] = '{5'sd0, 5'sd0, 5'sd1, -5'sd1,
                                               5'sd1, -5'sd1, 5'sd1, -5'sd1};
    localparam logic signed [4:0] DCOL [8] = '{5'sd1, -5'sd1, 5'sd0, 5'sd0,
                                               5'sd1, -5'sd1, -5'sd1, 5'sd1};

    // Coordinate k steps along delta, in 5 bits so that leaving the board
    // shows up as a value above 7 (negatives wrap to >= 16).
    function automatic logic [4:0] cell_sum(input logic [2:0] base,
                                            input logic signed [4:0] delta,
                                            input logic [K_W-1:0] k);
        return {2'b00, base} + (delta * $signed({{(5-K_W){1'b0}}, k}));
    endfunction

    function automatic logic cell_ok(input logic [2:0] base,
                                     input logic signed [4:0] delta,
                                     input logic [K_W-1:0] k);
        return cell_sum(base, delta, k) <= 5'd7;
    endfunction

    function automatic logic [2:0] cell_idx(input logic [2:0] base,
                                            input logic signed [4:0] delta,
                                            input logic [K_W-1:0] k);
        return base + 3'(delta * $signed({{(5-K_W){1'b0}}, k}));
    endfunction

    state_t             state_q, state_d;
    logic [INIT_W-1:0]  init_cnt_q, init_cnt_d;
    logic [2:0]         row_q, row_d, col_q, col_d;
    logic [2:0]         dir_q, dir_d;
    logic [K_W-1:0]     k_q, k_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [6:0]         moves_q, moves_d;
    logic [1:0]         player_q, player_d, winner_q, winner_d;
    logic               over_q, over_d, draw_q, draw_d, reject_q, reject_d;

    // Directions whose first step from the dropped piece lies on the board.
    // Directions that fail here are skipped without spending a read cycle.
    logic [7:0] first_ok;
    genvar gi;
    for (gi = 0; gi < 8; gi++) begin : g_dir
        assign first_ok[gi] = cell_ok(row_q, DROW[gi], K_W'(1)) &&
                              cell_ok(col_q, DCOL[gi], K_W'(1));
    end

    logic [2:0] first_dir, next_dir;
    logic       next_found;
    always_comb begin
        first_dir  = '0;
        next_dir   = '0;
        next_found = 1'b0;
        for (int i = 7; i >= 0; i--) begin
            if (first_ok[i]) begin
                first_dir = 3'(i);
                if (i > int'(dir_q)) begin
                    next_dir   = 3'(i);
                    next_found = 1'b1;
                end
            end
        end
    end

    logic [K_W-1:0]   k_inc;
    logic [CNT_W-1:0] cnt_hit, cnt_end;
    logic             match, step_ok, disp_sel;

    assign k_inc   = k_q + K_W'(1);
    assign cnt_hit = cnt_q + CNT_W'(1);
    assign match   = (board_data_out == player_q);
    assign step_ok = cell_ok(row_q, DROW[dir_q], k_inc) &&
                     cell_ok(col_q, DCOL[dir_q], k_inc);
    assign cnt_end = match ? cnt_hit : cnt_q;

    always_comb begin
        state_d       = state_q;
        init_cnt_d    = init_cnt_q;
        row_d         = row_q;
        col_d         = col_q;
        dir_d         = dir_q;
        k_d           = k_q;
        cnt_d         = cnt_q;
        moves_d       = moves_q;
        player_d      = player_q;
        winner_d      = winner_q;
        over_d        = over_q;
        draw_d        = draw_q;
        reject_d      = 1'b0;
        move_ready    = 1'b0;
        board_enable  = 1'b0;
        board_row     = '0;
        board_col     = '0;
        board_data_in = '0;
        board_write   = 1'b0;
        disp_sel      = 1'b0;
        disp_grant    = 1'b0;
        disp_data     = '0;

        unique case (state_q)
            INIT: begin
                init_cnt_d = init_cnt_q + INIT_W'(1);
                if (init_cnt_q == INIT_W'(INIT_CYCLES - 1)) state_d = IDLE;
            end
            IDLE: begin
                move_ready = 1'b1;
                if (move_valid) begin
                    // Address the requested column so the store reports its fill.
                    board_enable = 1'b1;
                    board_col    = move_col;
                    if (board_drop_allowed && !board_row_to_drop[3]) begin
                        col_d   = move_col;
                        row_d   = board_row_to_drop[2:0];
                        state_d = DROP;
                    end else begin
                        reject_d = 1'b1;
                    end
                end else begin
                    disp_sel = 1'b1;
                end
            end
            DROP: begin
                board_enable  = 1'b1;
                board_write   = 1'b1;
                board_row     = row_q;
                board_col     = col_q;
                board_data_in = player_q;
                moves_d       = moves_q + 7'd1;
                dir_d         = first_dir;
                k_d           = K_W'(1);
                cnt_d         = CNT_W'(1);
                state_d       = SCAN;
            end
            SCAN: begin
                board_row    = cell_idx(row_q, DROW[dir_q], k_q);
                board_col    = cell_idx(col_q, DCOL[dir_q], k_q);
                board_enable = cell_ok(row_q, DROW[dir_q], k_q) &&
                               cell_ok(col_q, DCOL[dir_q], k_q);
                if (match && cnt_hit >= CNT_W'(WIN_LEN)) begin
                    winner_d = player_q;
                    over_d   = 1'b1;
                    state_d  = OVER;
                end else if (match && k_q != K_W'(WIN_LEN - 1) && step_ok) begin
                    k_d   = k_inc;
                    cnt_d = cnt_hit;
                end else if (next_found) begin
                    // Count carries over only within the same axis pair.
                    dir_d = next_dir;
                    k_d   = K_W'(1);
                    cnt_d = (next_dir[2:1] == dir_q[2:1]) ? cnt_end : CNT_W'(1);
                end else if (moves_q == 7'd64) begin
                    draw_d  = 1'b1;
                    over_d  = 1'b1;
                    state_d = OVER;
                end else begin
                    player_d = (player_q == 2'b01) ? 2'b10 : 2'b01;
                    state_d  = IDLE;
                end
            end
            OVER: begin
                disp_sel = 1'b1;
            end
            default: state_d = INIT;
        endcase

        if (disp_sel) begin
            board_enable = 1'b1;
            board_row    = disp_row;
            board_col    = disp_col;
            disp_grant   = 1'b1;
            disp_data    = board_data_out;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= INIT;
            init_cnt_q <= '0;
            row_q      <= '0;
            col_q      <= '0;
            dir_q      <= '0;
            k_q        <= '0;
            cnt_q      <= '0;
            moves_q    <= '0;
            player_q   <= 2'b01;
            winner_q   <= 2'b00;
            over_q     <= 1'b0;
            draw_q     <= 1'b0;
            reject_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            init_cnt_q <= init_cnt_d;
            row_q      <= row_d;
            col_q      <= col_d;
            dir_q      <= dir_d;
            k_q        <= k_d;
            cnt_q      <= cnt_d;
            moves_q    <= moves_d;
            player_q   <= player_d;
            winner_q   <= winner_d;
            over_q     <= over_d;
            draw_q     <= draw_d;
            reject_q   <= reject_d;
        end
    end

    assign move_reject    = reject_q;
    assign current_player = player_q;
    assign winner         = winner_q;
    assign game_over      = over_q;
    assign draw           = draw_q;

endmodule
